if_id_stage_reg: RTL
====================

Name: if_id_stage_reg

Overview:
IF/ID pipeline register and the bubble injector for the 5-stage RV32I core. It receives the stall level produced by the stall controller and the active-low redirect (pc_sel) from EX. It holds or squashes the fetched instruction, drives the PC write enable, and presents a valid/NOP instruction to decode. It sits between the instruction memory output and the decoder.

Parameters:
XLEN, 32, width of PC.
NOP_INSTR, 32'h0000_0013, encoding injected as a bubble (ADDI x0,x0,0).
RESET_PC, 0, value reported on d_pc after reset.

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous active-high reset
pc_sel  in  1  active-low redirect from EX; 0 = taken branch/jump this cycle
stall  in  1  active-high stall level from stall controller
f_pc  in  XLEN  PC of instruction currently fetched
f_instr  in  32  instruction word from instruction memory
pc_we  out  1  PC register write enable (combinational)
d_pc  out  XLEN  registered PC to ID
d_instr  out  32  registered instruction to ID
d_valid  out  1  1 = d_instr is a real instruction, 0 = bubble
state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (rst=1 at an edge): d_pc=RESET_PC, d_instr=NOP_INSTR, d_valid=0, state=RUN. rst overrides every other input in the same cycle.
- FSM states:
  - RUN=2'b00: normal capture.
  - SQUASH=2'b01: wrong-path bubbles are being injected.
  - RESUME=2'b10: one cycle for the first correct-path capture.
- Priority per edge: rst > (pc_sel==0) > stall > normal.
- pc_sel==0 (any state): next state SQUASH, d_instr<=NOP_INSTR, d_valid<=0, d_pc holds.
- stall==1 with pc_sel==1: next/stay SQUASH, d_instr<=NOP_INSTR, d_valid<=0, d_pc holds.
- SQUASH with stall==0 and pc_sel==1: capture f_pc/f_instr, d_valid<=1, next RESUME.
- RESUME: behaves as RUN for capture. Next state is RUN unless a redirect or stall occurs.
- RUN with stall==0 and pc_sel==1: d_pc<=f_pc, d_instr<=f_instr, d_valid<=1.
- pc_we = ~stall | ~pc_sel. The redirect target must always be written. The PC is frozen only while stall is high without a new redirect.
- Latency: one cycle from f_* to d_*. No combinational path from f_instr to d_instr.
- Back-to-back redirects: each pc_sel low re-enters SQUASH. The bubble count restarts from the stall controller's side, and no valid instruction leaks between them.
- stall asserted while in RUN without a redirect (e.g. a stall controller glitch after reset): treat as squash. No instruction is lost, because the PC is also frozen.
- Reset mid-SQUASH: returns to RUN with d_valid=0. The first valid capture is on the first edge after rst falls, with stall=0.
- Illegal state 2'b11: next state RUN, outputs as reset values.

Optional Feature:
IF_ID_BUBBLE_CNT_EN
- Defined: adds output bubble_cnt[15:0]. It increments on every edge where d_valid is loaded with 0 (excluding rst). It saturates at 16'hFFFF and clears on rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package rv_pipe_pkg holds:
  - XLEN default.
  - NOP_INSTR constant.
  - The 2-bit state encoding constants ST_RUN, ST_SQUASH, ST_RESUME.
- The stall controller and ID/EX register reuse NOP_INSTR from this package.
- One sub-module is natural: sat_counter (WIDTH parameter, inc, clr), used for bubble_cnt when the macro is defined.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with f_instr=32'h00500093, then release with stall=0 and pc_sel=1.
   - Required: d_valid=0 and d_instr=32'h00000013 during reset.
   - Required: one cycle after release, d_pc=f_pc and d_instr=32'h00500093 with d_valid=1.
2. Straight-line code: f_pc=0,4,8,12 on consecutive cycles with stall=0.
   - Required: d_pc follows one cycle later (0,4,8,12), d_valid=1, pc_we=1 throughout.
3. Taken branch: pc_sel=0 at f_pc=16, then stall=1 for 3 cycles, then stall=0 with f_pc=64.
   - Required: 4 bubbles (d_instr=NOP, d_valid=0), then d_pc=64 with d_valid=1.
   - Required: state sequence SQUASH×4 → RESUME → RUN.
4. Back-to-back redirects: pc_sel=0 at two edges 2 cycles apart.
   - Required: d_valid stays 0 from the first redirect until stall falls after the second.
   - Required: pc_we=1 on both redirect cycles.
5. Reset mid-squash: assert rst during the second bubble.
   - Required: state=RUN and d_pc=RESET_PC next edge.
   - Required: with IF_ID_BUBBLE_CNT_EN defined, bubble_cnt=0.
6. With IF_ID_BUBBLE_CNT_EN defined: run scenario 3 twice.
   - Required: bubble_cnt=8.
   - Required: force 65540 bubbles → bubble_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants for the 5-stage RV32I core.
// Holds the PC width default, the bubble encoding and the IF/ID FSM state encoding.
// Reused by the stall controller and the ID/EX register.
package rv_pipe_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,  // normal capture
        ST_SQUASH = 2'b01,  // wrong-path bubbles being injected
        ST_RESUME = 2'b10   // first correct-path capture after a squash
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the edge after inc; clr wins over inc.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with bubble injection on redirect/stall.
// Latency: one cycle f_* -> d_*; no combinational path from f_instr to d_instr.
// Backpressure: stall freezes the PC (pc_we=0) and injects NOPs; a redirect always writes the PC.
// Optional: define IF_ID_BUBBLE_CNT_EN to add a saturating bubble_cnt output.
module if_id_stage_reg #(
    parameter int              XLEN      = rv_pipe_pkg::XLEN,
    parameter logic [31:0]     NOP_INSTR = rv_pipe_pkg::NOP_INSTR,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_sel,
    input  logic            stall,
    input  logic [XLEN-1:0] f_pc,
    input  logic [31:0]     f_instr,
    output logic            pc_we,
    output logic [XLEN-1:0] d_pc,
    output logic [31:0]     d_instr,
    output logic            d_valid,
`ifdef IF_ID_BUBBLE_CNT_EN
    output logic [15:0]     bubble_cnt,
`endif
    output logic [1:0]      state_o
);

    import rv_pipe_pkg::*;

    state_e          state_q,   state_d;
    logic [XLEN-1:0] d_pc_q,    d_pc_d;
    logic [31:0]     d_instr_q, d_instr_d;
    logic            d_valid_q, d_valid_d;

    // Next state and next IF/ID contents: redirect > stall > capture.
    always_comb begin
        state_d   = state_q;
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        d_valid_d = d_valid_q;
        case (state_q)
            ST_RUN, ST_SQUASH, ST_RESUME: begin
                if (!pc_sel || stall) begin
                    // Wrong-path or frozen fetch: inject a bubble, keep the old PC.
                    state_d   = ST_SQUASH;
                    d_instr_d = NOP_INSTR;
                    d_valid_d = 1'b0;
                end else begin
                    state_d   = (state_q == ST_SQUASH) ? ST_RESUME : ST_RUN;
                    d_pc_d    = f_pc;
                    d_instr_d = f_instr;
                    d_valid_d = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: recover to the reset picture.
                state_d   = ST_RUN;
                d_pc_d    = RESET_PC;
                d_instr_d = NOP_INSTR;
                d_valid_d = 1'b0;
            end
        endcase
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            d_pc_q    <= RESET_PC;
            d_instr_q <= NOP_INSTR;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_valid_q <= d_valid_d;
        end
    end

    // A redirect target must land even while stalled.
    assign pc_we   = ~stall | ~pc_sel;
    assign d_pc    = d_pc_q;
    assign d_instr = d_instr_q;
    assign d_valid = d_valid_q;
    assign state_o = state_q;

`ifdef IF_ID_BUBBLE_CNT_EN
    sat_counter #(
        .WIDTH (16)
    ) u_bubble_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (~d_valid_d),
        .cnt_o (bubble_cnt)
    );
`endif

endmodule
